// File: rtl/six_bit_mult_arbiter.sv
// Two-requester arbiter sharing one 6x6 unsigned multiplier (round-robin on contention).
// Latency: resp_valid rises MUL_CYCLES cycles after the acceptance edge; issue interval >= MUL_CYCLES+2.
// Backpressure: product/id held while resp_ready is low; no request accepted until the response drains.

module six_bit_dadda_mutliplier (
   input  logic [5:0]  in1,
   input  logic [5:0]  in2,
   output logic [11:0] out
);

   logic [11:0] w_pp [6];

   // Partial-product rows: row i is in1 gated by in2[i], weighted by 2^i.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         w_pp[i] = {6'd0, in1 & {6{in2[i]}}} << i;
      end
   end

   // Reduce the partial-product array to the full-width 12-bit product.
   assign out = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3] + w_pp[4] + w_pp[5];

endmodule

module six_bit_mult_arbiter #(
   parameter int MUL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [5:0]  req0_a,
   input  logic [5:0]  req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [5:0]  req1_a,
   input  logic [5:0]  req1_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [11:0] resp_product,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      RESP    = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic        r_ptr;
   logic [3:0]  r_cnt;
   logic [5:0]  r_a;
   logic [5:0]  r_b;
   logic        r_id;
   logic        r_resp_id;
   logic [11:0] r_resp_product;

   logic        w_grant0;
   logic        w_grant1;
   logic        w_accept;
   logic        w_last;
   logic        w_ready0;
   logic        w_ready1;
   logic        w_resp_valid;
   logic        w_busy;
   logic [11:0] w_mul_out;

   // Pointer only breaks ties; a lone valid requester always wins.
   assign w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
   assign w_grant1 = req1_valid & (~req0_valid |  r_ptr);
   assign w_last   = (r_cnt == 4'(MUL_CYCLES - 1));

   // Multiplier sees only the captured operands, so requester inputs may change in flight.
   six_bit_dadda_mutliplier u_mul (
      .in1 (r_a),
      .in2 (r_b),
      .out (w_mul_out)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      w_next_state = r_state;
      w_ready0     = 1'b0;
      w_ready1     = 1'b0;
      w_accept     = 1'b0;
      w_resp_valid = 1'b0;
      w_busy       = 1'b1;
      case (r_state)
         IDLE: begin
            w_busy   = 1'b0;
            w_ready0 = w_grant0;
            w_ready1 = w_grant1;
            w_accept = w_grant0 | w_grant1;
            if (w_accept) begin
               w_next_state = COMPUTE;
            end
         end
         COMPUTE: begin
            if (w_last) begin
               w_next_state = RESP;
            end
         end
         RESP: begin
            w_resp_valid = 1'b1;
            // Returning to IDLE here; the new grant is evaluated next cycle.
            if (resp_ready) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Operand capture, pointer update, settle counter and result latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr          <= 1'b0;
         r_cnt          <= 4'd0;
         r_a            <= 6'd0;
         r_b            <= 6'd0;
         r_id           <= 1'b0;
         r_resp_id      <= 1'b0;
         r_resp_product <= 12'd0;
      end else if (w_accept) begin
         r_a   <= w_grant1 ? req1_a : req0_a;
         r_b   <= w_grant1 ? req1_b : req0_b;
         r_id  <= w_grant1;
         r_ptr <= ~w_grant1;
         r_cnt <= 4'd0;
      end else if (r_state == COMPUTE) begin
         r_cnt <= r_cnt + 4'd1;
         if (w_last) begin
            r_resp_product <= w_mul_out;
            r_resp_id      <= r_id;
         end
      end
   end

   // Ready is forced low while reset is asserted, even though IDLE decode is combinational.
   assign req0_ready   = w_ready0 & rst_n;
   assign req1_ready   = w_ready1 & rst_n;
   assign resp_valid   = w_resp_valid;
   assign resp_id      = r_resp_id;
   assign resp_product = r_resp_product;
   assign busy         = w_busy;

endmodule

// File: tb/tb_six_bit_mult_arbiter.sv
// Bench for six_bit_mult_arbiter: instance 0 with MUL_CYCLES=1, instance 1 with MUL_CYCLES=3.
// Reference model: products by plain arithmetic, winner from a tie-break pointer, latency = MUL_CYCLES.
// Inputs driven on the falling edge; outputs sampled 1 time unit after the falling edge.

module tb_six_bit_mult_arbiter;

   logic        clk;
   logic        rst_n [2];
   logic        v0 [2];
   logic        rd0 [2];
   logic [5:0]  a0 [2];
   logic [5:0]  b0 [2];
   logic        v1 [2];
   logic        rd1 [2];
   logic [5:0]  a1 [2];
   logic [5:0]  b1 [2];
   logic        rv [2];
   logic        rr [2];
   logic        rid [2];
   logic [11:0] rp [2];
   logic        bsy [2];

   int total = 0;
   int bad   = 0;
   int exp_ptr [2];
   int mulc [2];

   six_bit_mult_arbiter #(.MUL_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n[0]),
      .req0_valid(v0[0]), .req0_ready(rd0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
      .req1_valid(v1[0]), .req1_ready(rd1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
      .resp_valid(rv[0]), .resp_ready(rr[0]), .resp_id(rid[0]), .resp_product(rp[0]),
      .busy(bsy[0])
   );

   six_bit_mult_arbiter #(.MUL_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n[1]),
      .req0_valid(v0[1]), .req0_ready(rd0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
      .req1_valid(v1[1]), .req1_ready(rd1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
      .resp_valid(rv[1]), .resp_ready(rr[1]), .resp_id(rid[1]), .resp_product(rp[1]),
      .busy(bsy[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [11:0] pm(input logic [5:0] a, input logic [5:0] b);
      int p;
      p = int'(a) * int'(b);
      return 12'(p);
   endfunction

   function automatic int model_win(input int k, input logic va, input logic vb);
      if (va && !vb) return 0;
      if (vb && !va) return 1;
      return exp_ptr[k];
   endfunction

   task automatic drive(input int k, input logic iv0, input logic [5:0] ia0, input logic [5:0] ib0,
                        input logic iv1, input logic [5:0] ia1, input logic [5:0] ib1);
      v0[k] = iv0; a0[k] = ia0; b0[k] = ib0;
      v1[k] = iv1; a1[k] = ia1; b1[k] = ib1;
   endtask

   task automatic apply_reset(input int k);
      @(negedge clk);
      drive(k, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
      rr[k]    = 1'b1;
      rst_n[k] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n[k]   = 1'b1;
      exp_ptr[k] = 0;
   endtask

   // Waits for a grant, then for resp_valid; returns at the falling edge where resp_valid is first seen.
   task automatic run_txn(input int k, input bit scramble, output int win, output logic [11:0] prod,
                          output int pid, output int lat, output logic [11:0] e0,
                          output logic [11:0] e1, output bit to);
      bit seen;
      to = 1'b0; win = -1; lat = 0; prod = 12'd0; pid = 0; e0 = 12'd0; e1 = 12'd0; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (v0[k] && rd0[k]) win = 0;
         else if (v1[k] && rd1[k]) win = 1;
         if (win >= 0) break;
         @(negedge clk);
      end
      if (win < 0) begin
         to = 1'b1;
         return;
      end
      e0 = pm(a0[k], b0[k]);
      e1 = pm(a1[k], b1[k]);
      @(posedge clk);
      if (scramble) begin
         #1;
         a0[k] = 6'($urandom); b0[k] = 6'($urandom);
         a1[k] = 6'($urandom); b1[k] = 6'($urandom);
      end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (rv[k]) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         to = 1'b1;
         return;
      end
      prod = rp[k];
      pid  = int'(rid[k]);
   endtask

   task automatic test_reset;
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 1'b0;
         rr[k]    = 1'b1;
         drive(k, 1'b1, 6'd5, 6'd7, 1'b1, 6'd9, 6'd3);
      end
      #12;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (rd0[k] !== 1'b0 || rd1[k] !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready k=%0d got=%b%b want=00", k, rd0[k], rd1[k]);
         end
         total++;
         if (rv[k] !== 1'b0 || bsy[k] !== 1'b0 || rid[k] !== 1'b0 || rp[k] !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs k=%0d got rv=%b busy=%b id=%b prod=%0d want all 0",
                     k, rv[k], bsy[k], rid[k], rp[k]);
         end
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         drive(k, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
         rst_n[k]   = 1'b1;
         exp_ptr[k] = 0;
      end
   endtask

   task automatic test_single;
      int w, pid, lat; logic [11:0] p, e0, e1; bit to;
      apply_reset(0);
      drive(0, 1'b1, 6'd63, 6'd51, 1'b0, 6'd0, 6'd0);
      run_txn(0, 1'b0, w, p, pid, lat, e0, e1, to);
      drive(0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
      total++;
      if (to || w != 0 || lat != 1) begin
         bad++;
         $display("FAIL single_grant_latency got timeout=%0d win=%0d lat=%0d want win=0 lat=1", to, w, lat);
      end
      total++;
      if (p !== 12'd3213 || pid != 0) begin
         bad++;
         $display("FAIL single_result got prod=%0d id=%0d want prod=3213 id=0", p, pid);
      end
      if (w >= 0) exp_ptr[0] = 1 - w;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_contention;
      int w, pid, lat; logic [11:0] p, e0, e1; bit to;
      int ew;
      apply_reset(0);
      drive(0, 1'b1, 6'd55, 6'd51, 1'b1, 6'd22, 6'd33);
      for (int n = 0; n < 2; n++) begin
         ew = model_win(0, 1'b1, 1'b1);
         run_txn(0, 1'b0, w, p, pid, lat, e0, e1, to);
         total++;
         if (to || w != ew || pid != ew) begin
            bad++;
            $display("FAIL contention_id n=%0d got win=%0d id=%0d timeout=%0d want %0d", n, w, pid, to, ew);
         end
         total++;
         if (p !== ((n == 0) ? 12'd2805 : 12'd726)) begin
            bad++;
            $display("FAIL contention_prod n=%0d got=%0d want=%0d", n, p, (n == 0) ? 2805 : 726);
         end
         exp_ptr[0] = 1 - ew;
         if (n == 1) drive(0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_fairness;
      int w, pid, lat; logic [11:0] p, e0, e1; bit to;
      int ew;
      apply_reset(0);
      drive(0, 1'b1, 6'($urandom), 6'($urandom), 1'b1, 6'($urandom), 6'($urandom));
      for (int n = 0; n < 6; n++) begin
         ew = model_win(0, 1'b1, 1'b1);
         run_txn(0, 1'b0, w, p, pid, lat, e0, e1, to);
         total++;
         if (to || pid != (n % 2) || pid != ew || p !== ((ew == 1) ? e1 : e0)) begin
            bad++;
            $display("FAIL fairness n=%0d got id=%0d prod=%0d want id=%0d prod=%0d",
                     n, pid, p, n % 2, (ew == 1) ? e1 : e0);
         end
         exp_ptr[0] = 1 - ew;
         if (n == 5) drive(0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure;
      int w, pid, lat; logic [11:0] p, e0, e1; bit to;
      int errs;
      apply_reset(0);
      rr[0] = 1'b0;
      drive(0, 1'b1, 6'd33, 6'd24, 1'b0, 6'd0, 6'd0);
      run_txn(0, 1'b0, w, p, pid, lat, e0, e1, to);
      if (w >= 0) exp_ptr[0] = 1 - w;
      total++;
      if (to || p !== 12'd792 || pid != 0) begin
         bad++;
         $display("FAIL bp_first got prod=%0d id=%0d timeout=%0d want 792 id 0", p, pid, to);
      end
      drive(0, 1'b1, 6'd1, 6'd2, 1'b1, 6'd3, 6'd4);
      errs = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (rv[0] !== 1'b1 || rp[0] !== 12'd792 || rid[0] !== 1'b0 || rd0[0] !== 1'b0 || rd1[0] !== 1'b0)
            errs++;
         @(negedge clk);
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL bp_hold got %0d bad cycles want 0 (last rv=%b prod=%0d)", errs, rv[0], rp[0]);
      end
      rr[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (bsy[0] !== 1'b0 || rv[0] !== 1'b0 || rd1[0] !== (exp_ptr[0] == 1)) begin
         bad++;
         $display("FAIL bp_release got busy=%b rv=%b rdy1=%b want 0 0 %0d", bsy[0], rv[0], rd1[0], exp_ptr[0] == 1);
      end
      drive(0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
      @(negedge clk);
   endtask

   task automatic test_boundary;
      int w, pid, lat; logic [11:0] p, e0, e1; bit to;
      apply_reset(1);
      drive(1, 1'b1, 6'd0, 6'd63, 1'b0, 6'd0, 6'd0);
      run_txn(1, 1'b1, w, p, pid, lat, e0, e1, to);
      drive(1, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
      total++;
      if (to || p !== 12'd0 || lat != 3 || pid != 0) begin
         bad++;
         $display("FAIL bound_zero got prod=%0d lat=%0d id=%0d want 0 3 0", p, lat, pid);
      end
      if (w >= 0) exp_ptr[1] = 1 - w;
      @(posedge clk);
      @(negedge clk);
      drive(1, 1'b0, 6'd0, 6'd0, 1'b1, 6'd63, 6'd63);
      run_txn(1, 1'b1, w, p, pid, lat, e0, e1, to);
      drive(1, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
      total++;
      if (to || p !== 12'd3969 || lat != 3 || pid != 1) begin
         bad++;
         $display("FAIL bound_max got prod=%0d lat=%0d id=%0d want 3969 3 1", p, lat, pid);
      end
      if (w >= 0) exp_ptr[1] = 1 - w;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_compute;
      int w, pid, lat; logic [11:0] p, e0, e1; bit to;
      int spurious;
      drive(1, 1'b1, 6'd10, 6'd10, 1'b0, 6'd0, 6'd0);
      @(posedge clk);
      @(negedge clk);
      drive(1, 1'b1, 6'd10, 6'd10, 1'b1, 6'd11, 6'd11);
      rst_n[1] = 1'b0;
      #1;
      total++;
      if (rv[1] !== 1'b0 || bsy[1] !== 1'b0 || rid[1] !== 1'b0 || rp[1] !== 12'd0 ||
          rd0[1] !== 1'b0 || rd1[1] !== 1'b0) begin
         bad++;
         $display("FAIL rst_compute_outputs got rv=%b busy=%b id=%b prod=%0d rdy=%b%b want all 0",
                  rv[1], bsy[1], rid[1], rp[1], rd0[1], rd1[1]);
      end
      @(negedge clk);
      drive(1, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
      rst_n[1]   = 1'b1;
      exp_ptr[1] = 0;
      spurious = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rv[1] !== 1'b0) spurious++;
      end
      total++;
      if (spurious != 0) begin
         bad++;
         $display("FAIL rst_compute_no_resp got %0d cycles with resp_valid want 0", spurious);
      end
      drive(1, 1'b1, 6'd2, 6'd3, 1'b1, 6'd4, 6'd5);
      run_txn(1, 1'b0, w, p, pid, lat, e0, e1, to);
      drive(1, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
      total++;
      if (to || w != 0 || pid != 0 || p !== 12'd6) begin
         bad++;
         $display("FAIL rst_compute_first_grant got win=%0d id=%0d prod=%0d want 0 0 6", w, pid, p);
      end
      if (w >= 0) exp_ptr[1] = 1 - w;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_valid_drop;
      int w, pid, lat; logic [11:0] p, e0, e1; bit to;
      bit seen;
      int ew;
      apply_reset(1);
      drive(1, 1'b0, 6'd0, 6'd0, 1'b1, 6'd7, 6'd9);
      #1;
      exp_ptr[1] = 0;
      @(posedge clk);
      @(negedge clk);
      drive(1, 1'b1, 6'd5, 6'd5, 1'b0, 6'd0, 6'd0);
      #1;
      total++;
      if (rd0[1] !== 1'b0 || bsy[1] !== 1'b1) begin
         bad++;
         $display("FAIL drop_no_ready got rdy0=%b busy=%b want 0 1", rd0[1], bsy[1]);
      end
      @(negedge clk);
      drive(1, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rv[1]) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      total++;
      if (!seen || rp[1] !== 12'd63 || rid[1] !== 1'b1) begin
         bad++;
         $display("FAIL drop_resp got seen=%0d prod=%0d id=%b want 1 63 1", seen, rp[1], rid[1]);
      end
      @(posedge clk);
      @(negedge clk);
      drive(1, 1'b1, 6'd8, 6'd8, 1'b1, 6'd9, 6'd9);
      ew = model_win(1, 1'b1, 1'b1);
      run_txn(1, 1'b0, w, p, pid, lat, e0, e1, to);
      drive(1, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
      total++;
      if (to || pid != ew || p !== ((ew == 1) ? e1 : e0)) begin
         bad++;
         $display("FAIL drop_next_grant got id=%0d prod=%0d want id=%0d", pid, p, ew);
      end
      exp_ptr[1] = 1 - ew;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_random;
      int w, pid, lat; logic [11:0] p, e0, e1; bit to;
      int pat, d, ew;
      logic [11:0] ep;
      for (int k = 0; k < 2; k++) begin
         apply_reset(k);
         for (int n = 0; n < 25; n++) begin
            pat = $urandom_range(1, 3);
            d   = $urandom_range(0, 2);
            rr[k] = (d == 0);
            drive(k, pat[0], 6'($urandom), 6'($urandom), pat[1], 6'($urandom), 6'($urandom));
            ew = model_win(k, pat[0], pat[1]);
            run_txn(k, 1'b1, w, p, pid, lat, e0, e1, to);
            ep = (ew == 1) ? e1 : e0;
            total++;
            if (to || w != ew || pid != ew || p !== ep || lat != mulc[k]) begin
               bad++;
               $display("FAIL random k=%0d n=%0d got win=%0d id=%0d prod=%0d lat=%0d want %0d %0d %0d %0d",
                        k, n, w, pid, p, lat, ew, ew, ep, mulc[k]);
            end
            exp_ptr[k] = 1 - ew;
            if (d > 0) begin
               repeat (d) @(negedge clk);
               #1;
               total++;
               if (rv[k] !== 1'b1 || rp[k] !== ep) begin
                  bad++;
                  $display("FAIL random_hold k=%0d n=%0d got rv=%b prod=%0d want 1 %0d", k, n, rv[k], rp[k], ep);
               end
               rr[k] = 1'b1;
            end
            drive(k, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0);
            @(posedge clk);
            @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
   endtask

   initial begin
      mulc[0] = 1;
      mulc[1] = 3;
      test_reset;
      test_single;
      test_contention;
      test_fairness;
      test_backpressure;
      test_boundary;
      test_reset_compute;
      test_valid_drop;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
